// File: rtl/delay_pkg.sv
// delay_pkg: shared defaults and depth-width helper for the configurable delay line.
package delay_pkg;
   localparam int DATA_WIDH_DEF   = 20;
   localparam int MAX_DEPTH_DEF   = 8;
   localparam int RESET_DEPTH_DEF = 2;
   function automatic int depth_w(input int max_depth);
      return $clog2(max_depth + 1);
   endfunction
endpackage

// File: rtl/delay_stage.sv
// delay_stage: one enable/data register pair; data loads only on an incoming beat.
module delay_stage
   import delay_pkg::*;
#(
   parameter int DATA_WIDH = DATA_WIDH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 prev_en,
   input  logic [DATA_WIDH-1:0] prev_data,
   output logic                 en,
   output logic [DATA_WIDH-1:0] data
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en   <= 1'b0;
         data <= '0;
      end else begin
         en <= prev_en & ~flush;
         if (prev_en) data <= prev_data;
      end
   end
endmodule

// File: rtl/delay_line_cfg.sv
// delay_line_cfg: enable-qualified delay line with guarded run-time latency 0..MAX_DEPTH,
// synchronous flush and occupancy status.
module delay_line_cfg
   import delay_pkg::*;
#(
   parameter int DATA_WIDH   = DATA_WIDH_DEF,
   parameter int MAX_DEPTH   = MAX_DEPTH_DEF,
   parameter int DEPTH_W     = depth_w(MAX_DEPTH),
   parameter int RESET_DEPTH = RESET_DEPTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic [DATA_WIDH-1:0] data_i,
   input  logic                 flush_i,
   input  logic                 cfg_ld_i,
   input  logic [DEPTH_W-1:0]   cfg_depth_i,
   output logic                 en_o,
   output logic [DATA_WIDH-1:0] data_o,
   output logic [DEPTH_W-1:0]   depth_o,
   output logic                 busy_o,
   output logic                 cfg_err_o
);
   logic [MAX_DEPTH:0]   en_r;
   logic [DATA_WIDH-1:0] data_r [MAX_DEPTH+1];
   logic                 cfg_ok;
   if (MAX_DEPTH < 1 || RESET_DEPTH < 0 || RESET_DEPTH > MAX_DEPTH) begin : g_bad_params
      $error("delay_line_cfg: need MAX_DEPTH >= 1 and 0 <= RESET_DEPTH <= MAX_DEPTH");
   end
   // Index 0 is the live input so depth 0 falls out of the same output mux.
   assign en_r[0]   = en_i & ~flush_i;
   assign data_r[0] = data_i;
   for (genvar k = 1; k <= MAX_DEPTH; k++) begin : g_stage
      delay_stage #(.DATA_WIDH(DATA_WIDH)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .flush     (flush_i),
         .prev_en   (en_r[k-1]),
         .prev_data (data_r[k-1]),
         .en        (en_r[k]),
         .data      (data_r[k])
      );
   end
   assign en_o   = en_r[depth_o];
   assign data_o = data_r[depth_o];
   assign busy_o = |en_r[MAX_DEPTH:1];
   // Uses pre-flush occupancy, so a load alongside a flush of live beats is refused.
   assign cfg_ok = (cfg_depth_i <= DEPTH_W'(MAX_DEPTH)) && !busy_o && !en_i;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth_o   <= DEPTH_W'(RESET_DEPTH);
         cfg_err_o <= 1'b0;
      end else begin
         if (cfg_ld_i && cfg_ok) depth_o <= cfg_depth_i;
         cfg_err_o <= cfg_ld_i & ~cfg_ok;
      end
   end
endmodule

// File: tb/tb_delay_line_cfg.sv
// tb_delay_line_cfg: directed stimulus with a queue scoreboard checked by a separate output monitor.
module tb_delay_line_cfg;
   typedef struct {
      logic [19:0] data;
      int          cyc;
   } beat_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en_i = 1'b0;
   logic [19:0] data_i = '0;
   logic        flush_i = 1'b0;
   logic        cfg_ld_i = 1'b0;
   logic [3:0]  cfg_depth_i = '0;
   logic        en_o;
   logic [19:0] data_o;
   logic [3:0]  depth_o;
   logic        busy_o;
   logic        cfg_err_o;
   beat_t       q[$];
   int          cyc = 0;
   int          dm = 2;
   int          checks = 0;
   int          failures = 0;

   delay_line_cfg dut (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .data_i(data_i), .flush_i(flush_i),
      .cfg_ld_i(cfg_ld_i), .cfg_depth_i(cfg_depth_i), .en_o(en_o), .data_o(data_o),
      .depth_o(depth_o), .busy_o(busy_o), .cfg_err_o(cfg_err_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: every output beat must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && en_o) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat: got data %0h expected no beat (cycle %0d)", data_o, cyc);
         end else begin
            beat_t b;
            b = q.pop_front();
            chk("beat_data", 32'(data_o), 32'(b.data));
            chk("beat_cycle", 32'(cyc), 32'(b.cyc));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
      en_i = 1'b0;
      flush_i = 1'b0;
      cfg_ld_i = 1'b0;
   endtask

   task automatic set_in(input logic e, input logic [19:0] d, input logic f,
                         input logic ld, input logic [3:0] cd);
      en_i = e;
      data_i = d;
      flush_i = f;
      cfg_ld_i = ld;
      cfg_depth_i = cd;
      if (f) q.delete();
      else if (e) q.push_back('{d, cyc + dm});
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      #12;
      chk("rst_en_o", 32'(en_o), 0);
      chk("rst_data_o", 32'(data_o), 0);
      chk("rst_depth_o", 32'(depth_o), 2);
      chk("rst_busy_o", 32'(busy_o), 0);
      chk("rst_cfg_err_o", 32'(cfg_err_o), 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      // Default depth 2, back-to-back beats
      set_in(1, 20'h00001, 0, 0, 0); tick();
      set_in(1, 20'h00002, 0, 0, 0); tick();
      set_in(1, 20'h00003, 0, 0, 0); tick();
      idle(10);
      chk("drain_a", 32'(q.size()), 0);
      chk("depth_a", 32'(depth_o), 2);
      chk("cfg_err_a", 32'(cfg_err_o), 0);
      // Depth 5, sparse beats and hold between beats
      set_in(0, 0, 0, 1, 5); tick(); dm = 5;
      @(negedge clk);
      chk("depth_b", 32'(depth_o), 5);
      chk("cfg_err_b", 32'(cfg_err_o), 0);
      tick();
      set_in(1, 20'hABCDE, 0, 0, 0); tick();
      idle(3);
      set_in(1, 20'h12345, 0, 0, 0); tick();
      tick();
      @(negedge clk);
      chk("hold_en_o", 32'(en_o), 0);
      chk("hold_data_o", 32'(data_o), 32'h000ABCDE);
      chk("busy_b", 32'(busy_o), 1);
      idle(12);
      chk("drain_b", 32'(q.size()), 0);
      chk("idle_busy_b", 32'(busy_o), 0);
      // Rejections: busy, out of range (back-to-back), en_i in same cycle
      set_in(1, 20'h55555, 0, 0, 0); tick();
      set_in(0, 0, 0, 1, 3); tick();
      @(negedge clk);
      chk("rej_busy_err", 32'(cfg_err_o), 1);
      chk("rej_busy_depth", 32'(depth_o), 5);
      tick();
      @(negedge clk);
      chk("rej_busy_err_end", 32'(cfg_err_o), 0);
      idle(10);
      set_in(0, 0, 0, 1, 9); tick();
      @(negedge clk);
      chk("rej_9_err", 32'(cfg_err_o), 1);
      chk("rej_9_depth", 32'(depth_o), 5);
      set_in(0, 0, 0, 1, 15); tick();
      @(negedge clk);
      chk("rej_15_err", 32'(cfg_err_o), 1);
      tick();
      @(negedge clk);
      chk("rej_15_err_end", 32'(cfg_err_o), 0);
      tick();
      set_in(1, 20'h77777, 0, 1, 1); tick();
      @(negedge clk);
      chk("rej_en_err", 32'(cfg_err_o), 1);
      chk("rej_en_depth", 32'(depth_o), 5);
      idle(11);
      chk("drain_c", 32'(q.size()), 0);
      // Depth 0 pass-through and flush masking
      set_in(0, 0, 0, 1, 0); tick(); dm = 0;
      @(negedge clk);
      chk("depth_d", 32'(depth_o), 0);
      tick();
      set_in(1, 20'h0F0F0, 0, 0, 0);
      @(negedge clk);
      chk("pass_en_o", 32'(en_o), 1);
      chk("pass_data_o", 32'(data_o), 32'h000F0F0);
      tick();
      set_in(1, 20'h0BAD0, 1, 0, 0);
      @(negedge clk);
      chk("pass_flush_en_o", 32'(en_o), 0);
      tick();
      @(negedge clk);
      chk("flush_busy_d", 32'(busy_o), 0);
      // Depth 4 with flush in the second beat cycle
      set_in(0, 0, 0, 1, 4); tick(); dm = 4;
      @(negedge clk);
      chk("depth_e", 32'(depth_o), 4);
      tick();
      set_in(1, 20'h00A01, 0, 0, 0); tick();
      set_in(1, 20'h00A02, 1, 0, 0); tick();
      set_in(1, 20'h00A03, 0, 0, 0);
      @(negedge clk);
      chk("flush_busy_e", 32'(busy_o), 0);
      tick();
      set_in(1, 20'h00A04, 0, 0, 0); tick();
      idle(10);
      chk("drain_e", 32'(q.size()), 0);
      // Depth 6, async reset while a beat is on the output
      set_in(0, 0, 0, 1, 6); tick(); dm = 6;
      @(negedge clk);
      chk("depth_f", 32'(depth_o), 6);
      tick();
      set_in(1, 20'h00B01, 0, 0, 0); tick();
      set_in(1, 20'h00B02, 0, 0, 0); tick();
      set_in(1, 20'h00B03, 0, 0, 0); tick();
      idle(3);
      @(negedge clk);
      chk("pre_rst_en_o", 32'(en_o), 1);
      #2;
      rst_n = 1'b0;
      q.delete();
      dm = 2;
      #1;
      chk("mid_rst_en_o", 32'(en_o), 0);
      chk("mid_rst_data_o", 32'(data_o), 0);
      chk("mid_rst_depth_o", 32'(depth_o), 2);
      chk("mid_rst_busy_o", 32'(busy_o), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(12);
      chk("final_queue", 32'(q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/delay_line_cfg.md
# delay_line_cfg

Enable-qualified delay line with run-time programmable latency of 0..MAX_DEPTH cycles. It is the parametrised successor of the fixed two-stage enable/data delay used to align sample streams and enables inside the predictor datapath. It adds a synchronous flush, guarded run-time depth reconfiguration and pipeline-occupancy status. Each data stage loads only when the enable entering that stage is high, so a stage holds its last valid sample between beats.

## Interface
- DATA_WIDH, 20, sample width in bits
- MAX_DEPTH, 8, number of physical stages (≥1)
- DEPTH_W, $clog2(MAX_DEPTH+1), width of depth fields
- RESET_DEPTH, 2, latency selected after reset (≤ MAX_DEPTH)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- en_i  in  1  input beat valid
- data_i  in  DATA_WIDH  input sample
- flush_i  in  1  synchronous flush: discard all in-flight beats
- cfg_ld_i  in  1  request to load a new latency
- cfg_depth_i  in  DEPTH_W  requested latency
- en_o  out  1  output beat valid
- data_o  out  DATA_WIDH  output sample
- depth_o  out  DEPTH_W  currently active latency
- busy_o  out  1  any beat in flight in stages 1..MAX_DEPTH
- cfg_err_o  out  1  one-cycle pulse: last cfg_ld_i was rejected

## Operation
- Stage chain k = 1..MAX_DEPTH, stage 0 = inputs. en_r[k] <= en_r[k-1]; data_r[k] <= data_r[k-1] only when en_r[k-1] = 1, otherwise held.
- Stage-0 enable fed into the chain is en_i & ~flush_i.
- Output mux: depth_o = 0 → en_o = en_i & ~flush_i, data_o = data_i (combinational pass-through). depth_o = d > 0 → en_o = en_r[d], data_o = data_r[d].
- Flush: when flush_i = 1, every en_r[k] clears on the next edge. data_r is not cleared. The en_i beat presented in the flush cycle is dropped.
- busy_o = OR of en_r[1..MAX_DEPTH], registered-stage based with no combinational path from en_i.
- Reconfiguration on cfg_ld_i = 1 is evaluated in the same cycle:
  - Accept if cfg_depth_i ≤ MAX_DEPTH, busy_o = 0 and en_i = 0. depth_o takes cfg_depth_i on the next edge.
  - Otherwise reject: depth_o is unchanged and cfg_err_o = 1 for exactly the next cycle.
- cfg_ld_i together with flush_i: the cfg check uses the pre-flush busy_o, so the load is rejected if beats were in flight.
- Stages beyond depth_o keep shifting. Their beats are invisible at the output but still count toward busy_o.

## Timing
- Reset (async assert, sync-safe deassert by system): en_r, data_r = 0; en_o = 0; data_o = 0; depth_o = RESET_DEPTH; busy_o = 0; cfg_err_o = 0.
- Latency en_i→en_o and data_i→data_o = depth_o cycles exactly. Full throughput: one beat per cycle, no backpressure.
- depth change is effective for the first beat presented the cycle after acceptance.
- cfg_err_o is registered: it asserts one cycle after the offending cfg_ld_i and lasts one cycle per rejected request. Back-to-back rejects give back-to-back pulses.
- Reset asserted mid-stream: all in-flight beats are lost immediately (asynchronous), and depth reverts to RESET_DEPTH.
- Flush is effective next edge. en_o of a depth>0 output is 0 from the cycle after flush_i.

## Structure
- Shared package delay_pkg holds:
  - the depth-width function, clog2 of MAX_DEPTH+1;
  - the default constants DATA_WIDH_DEF = 20, MAX_DEPTH_DEF = 8, RESET_DEPTH_DEF = 2.
- Natural sub-module: delay_stage, containing one en/data register pair with data load gated by the incoming enable and an en clear on flush. It is instantiated MAX_DEPTH times in a generate loop. The top level holds the output mux, the cfg guard and the status logic.
- Elaboration check: RESET_DEPTH ≤ MAX_DEPTH, MAX_DEPTH ≥ 1.

## Test plan
- Reset, MAX_DEPTH = 8, no cfg: send en_i beats 0x00001, 0x00002, 0x00003 on consecutive cycles → same values on en_o/data_o 2 cycles later. depth_o = 2, cfg_err_o = 0.
- Idle, cfg_ld_i with cfg_depth_i = 5 → depth_o = 5 next cycle. Sparse beats 0xABCDE (gap 3) → each emerges exactly 5 cycles later, and data_o holds 0xABCDE between beats.
- cfg_depth_i = 0 accepted → en_o/data_o equal en_i/data_i in the same cycle, including with flush_i = 0.
- Beat in flight (busy_o = 1) and cfg_ld_i with depth 3 → rejected. cfg_err_o pulses 1 cycle, depth_o unchanged. cfg_depth_i = 9 while idle → also rejected.
- Depth 4, four consecutive beats, flush_i high in cycle 2 → no en_o for any beat issued at or before the flush cycle. busy_o = 0 the cycle after flush. A beat issued the cycle after flush emerges 4 cycles later.
- Depth 6 with 3 beats in flight, then assert rst_n low asynchronously mid-cycle → en_o = 0, data_o = 0, depth_o = 2 immediately, and no beat appears after release.
